// File: rtl/ax_approx_decider.sv
`default_nettype none
// ============================================================================
// Module  : ax_approx_decider
// Brief   : Per-lane approximate/keep decision from a shared Galois LFSR.
// Revision: 1.0
// ============================================================================
module ax_approx_decider #(
    parameter int unsigned                  WIDTH       = 4,
    parameter int unsigned                  LEVEL_WIDTH = 5,
    parameter int unsigned                  LFSR_WIDTH  = 32,
    parameter logic [LFSR_WIDTH-1:0]        LFSR_SEED   = 32'h0000_1010,
    parameter logic [LFSR_WIDTH-1:0]        LFSR_TAPS   = 32'h8020_0003
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            stall,
    input  logic                            flush,
    input  logic [WIDTH-1:0]                reqValid,
    input  logic [WIDTH*LEVEL_WIDTH-1:0]    reqLevel,
    input  logic                            reseedValid,
    input  logic [LFSR_WIDTH-1:0]           reseedValue,
    input  logic                            cntClear,
    output logic [WIDTH-1:0]                outValid,
    output logic [WIDTH-1:0]                outApprox,
    output logic [31:0]                     approxCount,
    output logic [LFSR_WIDTH-1:0]           lfsrState
);

    localparam int unsigned C_INC_W = $clog2(WIDTH + 1);

    logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0]      out_valid_q, out_valid_d;
    logic [WIDTH-1:0]      out_approx_q, out_approx_d;
    logic [31:0]           approx_count_q, approx_count_d;

    logic [WIDTH-1:0]      w_approx;
    logic                  w_accept;
    logic [C_INC_W-1:0]    w_inc;
    logic [32:0]           w_count_sum;

    // Each lane compares its level against a private, non-overlapping LFSR slice.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_lane
            assign w_approx[gi] = reqValid[gi] &
                (lfsr_q[LEVEL_WIDTH*gi +: LEVEL_WIDTH] < reqLevel[LEVEL_WIDTH*gi +: LEVEL_WIDTH]);
        end
    endgenerate

    assign w_accept = ~stall & ~flush & (|reqValid);

    always_comb begin
        w_inc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_inc = w_inc + C_INC_W'(w_approx[i]);
        end
        w_count_sum = {1'b0, approx_count_q} + 33'(w_inc);
    end

    always_comb begin
        lfsr_d         = lfsr_q;
        out_valid_d    = out_valid_q;
        out_approx_d   = out_approx_q;
        approx_count_d = approx_count_q;

        // Reseed wins over advance and never lets the register reach zero.
        if (reseedValid) begin
            lfsr_d = (reseedValue == '0) ? LFSR_SEED : reseedValue;
        end else if (w_accept) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
        end

        if (!stall) begin
            out_valid_d  = flush ? '0 : reqValid;
            out_approx_d = flush ? '0 : w_approx;
        end

        if (cntClear) begin
            approx_count_d = '0;
        end else if (!stall && !flush) begin
            approx_count_d = w_count_sum[32] ? 32'hFFFF_FFFF : w_count_sum[31:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q         <= LFSR_SEED;
            out_valid_q    <= '0;
            out_approx_q   <= '0;
            approx_count_q <= '0;
        end else begin
            lfsr_q         <= lfsr_d;
            out_valid_q    <= out_valid_d;
            out_approx_q   <= out_approx_d;
            approx_count_q <= approx_count_d;
        end
    end

    assign outValid    = out_valid_q;
    assign outApprox   = out_approx_q;
    assign approxCount = approx_count_q;
    assign lfsrState   = lfsr_q;

endmodule
`default_nettype wire

// File: tb/tb_ax_approx_decider.sv
`default_nettype none
// ============================================================================
// Module  : tb_ax_approx_decider
// Brief   : Directed vector table plus randomized run against a reference model.
// Revision: 1.0
// ============================================================================
module tb_ax_approx_decider;

    localparam logic [31:0] C_SEED = 32'h0000_1010;
    localparam logic [31:0] C_TAPS = 32'h8020_0003;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  reqValid = '0;
    logic [19:0] reqLevel = '0;
    logic        reseedValid = 1'b0;
    logic [31:0] reseedValue = '0;
    logic        cntClear = 1'b0;
    logic [3:0]  outValid;
    logic [3:0]  outApprox;
    logic [31:0] approxCount;
    logic [31:0] lfsrState;

    int n_checks = 0;
    int n_fail   = 0;

    ax_approx_decider dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .reqValid(reqValid), .reqLevel(reqLevel),
        .reseedValid(reseedValid), .reseedValue(reseedValue),
        .cntClear(cntClear), .outValid(outValid), .outApprox(outApprox),
        .approxCount(approxCount), .lfsrState(lfsrState)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        flush;
        logic [3:0]  valid;
        logic [19:0] level;
        logic        reseed;
        logic [31:0] seed;
        logic        clr;
        logic [3:0]  e_ov;
        logic [3:0]  e_oa;
        logic [31:0] e_cnt;
        logic [31:0] e_lfsr;
    } vec_t;

    vec_t vecs[12];

    // Reference model state
    logic [31:0] m_lfsr;
    logic [3:0]  m_ov;
    logic [3:0]  m_oa;
    longint      m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] ov, input logic [3:0] oa,
                             input logic [31:0] cnt, input logic [31:0] lf);
        chk({tag, ".outValid"},    32'(outValid),  32'(ov));
        chk({tag, ".outApprox"},   32'(outApprox), 32'(oa));
        chk({tag, ".approxCount"}, approxCount,    cnt);
        chk({tag, ".lfsrState"},   lfsrState,      lf);
    endtask

    // One clock of the specified behaviour, evaluated on the pre-edge state and inputs.
    task automatic model_step();
        logic [3:0] app;
        int         pop;
        bit         acc;
        pop = 0;
        for (int i = 0; i < 4; i++) begin
            int r, l;
            r = int'((m_lfsr >> (5 * i)) % 32);
            l = int'((reqLevel >> (5 * i)) % 32);
            app[i] = reqValid[i] && (r < l);
            if (app[i]) pop++;
        end
        acc = !stall && !flush && (reqValid != 0);
        if (!stall) begin
            m_ov = flush ? 4'b0 : reqValid;
            m_oa = flush ? 4'b0 : app;
        end
        if (cntClear) m_cnt = 0;
        else if (!stall && !flush) begin
            m_cnt = m_cnt + pop;
            if (m_cnt > 64'h0000_0000_FFFF_FFFF) m_cnt = 64'h0000_0000_FFFF_FFFF;
        end
        if (reseedValid) m_lfsr = (reseedValue == 0) ? C_SEED : reseedValue;
        else if (acc)    m_lfsr = m_lfsr[0] ? ((m_lfsr / 2) ^ C_TAPS) : (m_lfsr / 2);
    endtask

    initial begin
        //            stall flush valid  level                           rs    seed           clr  ov     oa     cnt  lfsr
        vecs[0]  = '{1'b0, 1'b0, 4'hF, {5'd17,5'd17,5'd17,5'd17}, 1'b0, 32'h0,         1'b0, 4'hF, 4'hF, 4,  32'h0000_0808};
        vecs[1]  = '{1'b0, 1'b0, 4'hF, {5'd0, 5'd0, 5'd0, 5'd0 }, 1'b0, 32'h0,         1'b0, 4'hF, 4'h0, 4,  32'h0000_0404};
        vecs[2]  = '{1'b1, 1'b0, 4'hF, {5'd31,5'd31,5'd31,5'd31}, 1'b0, 32'h0,         1'b0, 4'hF, 4'h0, 4,  32'h0000_0404};
        vecs[3]  = '{1'b1, 1'b0, 4'hF, {5'd31,5'd31,5'd31,5'd31}, 1'b0, 32'h0,         1'b0, 4'hF, 4'h0, 4,  32'h0000_0404};
        vecs[4]  = '{1'b1, 1'b0, 4'hF, {5'd31,5'd31,5'd31,5'd31}, 1'b0, 32'h0,         1'b0, 4'hF, 4'h0, 4,  32'h0000_0404};
        vecs[5]  = '{1'b0, 1'b0, 4'hF, {5'd31,5'd31,5'd31,5'd31}, 1'b0, 32'h0,         1'b0, 4'hF, 4'hF, 8,  32'h0000_0202};
        vecs[6]  = '{1'b1, 1'b1, 4'hF, {5'd31,5'd31,5'd31,5'd31}, 1'b0, 32'h0,         1'b0, 4'hF, 4'hF, 8,  32'h0000_0202};
        vecs[7]  = '{1'b0, 1'b1, 4'hF, {5'd31,5'd31,5'd31,5'd31}, 1'b0, 32'h0,         1'b0, 4'h0, 4'h0, 8,  32'h0000_0202};
        vecs[8]  = '{1'b0, 1'b0, 4'h0, {5'd31,5'd31,5'd31,5'd31}, 1'b1, 32'h0,         1'b0, 4'h0, 4'h0, 8,  32'h0000_1010};
        vecs[9]  = '{1'b0, 1'b0, 4'hF, {5'd0, 5'd4, 5'd1, 5'd16}, 1'b1, 32'hDEAD_BEEF, 1'b0, 4'hF, 4'h2, 9,  32'hDEAD_BEEF};
        vecs[10] = '{1'b1, 1'b0, 4'hF, {5'd31,5'd31,5'd31,5'd31}, 1'b1, 32'h1234_5678, 1'b0, 4'hF, 4'h2, 9,  32'h1234_5678};
        vecs[11] = '{1'b0, 1'b0, 4'h5, {5'd31,5'd31,5'd31,5'd31}, 1'b0, 32'h0,         1'b0, 4'h5, 4'h5, 11, 32'h091A_2B3C};

        // Reset values
        #12;
        check_all("reset", 4'h0, 4'h0, 32'h0, C_SEED);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        foreach (vecs[k]) begin
            stall       = vecs[k].stall;
            flush       = vecs[k].flush;
            reqValid    = vecs[k].valid;
            reqLevel    = vecs[k].level;
            reseedValid = vecs[k].reseed;
            reseedValue = vecs[k].seed;
            cntClear    = vecs[k].clr;
            @(negedge clk);
            check_all($sformatf("vec%0d", k), vecs[k].e_ov, vecs[k].e_oa, vecs[k].e_cnt, vecs[k].e_lfsr);
        end

        // Asynchronous reset in the middle of a cycle
        stall = 0; flush = 0; reqValid = 4'hF; reqLevel = '1; reseedValid = 0; cntClear = 0;
        #2 rst_n = 1'b0;
        #1 check_all("midreset", 4'h0, 4'h0, 32'h0, C_SEED);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized run against the model
        m_lfsr = C_SEED; m_ov = '0; m_oa = '0; m_cnt = 0;
        for (int n = 0; n < 400; n++) begin
            stall       = ($urandom_range(0, 7) == 0);
            flush       = ($urandom_range(0, 7) == 0);
            reqValid    = 4'($urandom);
            reqLevel    = 20'($urandom);
            reseedValid = ($urandom_range(0, 15) == 0);
            reseedValue = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
            cntClear    = !stall && ($urandom_range(0, 31) == 0);
            model_step();
            @(negedge clk);
            if (n % 20 == 0 || outValid !== m_ov || outApprox !== m_oa ||
                approxCount !== 32'(m_cnt) || lfsrState !== m_lfsr) begin
                check_all($sformatf("rand%0d", n), m_ov, m_oa, 32'(m_cnt), m_lfsr);
            end
        end

        // Saturation and clear priority
        stall = 0; flush = 0; reqValid = 4'h0; cntClear = 0;
        reseedValid = 1'b1; reseedValue = 32'h0;
        force dut.approx_count_q = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.approx_count_q;
        reseedValid = 1'b0;
        chk("sat.preload", approxCount, 32'hFFFF_FFFE);
        chk("sat.seed",    lfsrState,   C_SEED);
        reqValid = 4'hF; reqLevel = '1;
        @(negedge clk);
        chk("sat.first",  approxCount, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("sat.hold",   approxCount, 32'hFFFF_FFFF);
        reqValid = 4'h3; cntClear = 1'b1;
        @(negedge clk);
        chk("clr.prio",   approxCount, 32'h0);
        chk("clr.oa",     32'(outApprox), 32'h3);
        reqValid = 4'h1; cntClear = 1'b0;
        @(negedge clk);
        chk("clr.after",  approxCount, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
